butterfly_egress_port: RTL and testbench
========================================

Name: butterfly_egress_port

Overview:
- Downstream stage attached to one output port of the N-port butterfly network.
- Accepts routed flits of the form {dst_idx, payload} and checks the dst field against its own port index.
- Strips the header, buffers payloads in a small FIFO, and presents them to the local consumer over valid/ready.
- Detects misrouted flits, drops and counts them, and keeps delivered-flit statistics.

Parameters:
- DW, 35, flit width including header; header = top IW bits, where IW = $clog2(N).
- N, 8, network port count; power of 2, >= 2.
- PORT_ID, 0, index of this output port, 0..N-1.
- DEPTH, 4, payload FIFO depth; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  flit valid from butterfly output port
- i_ready  out  1  flit accept to butterfly output port
- i_data  in  DW  flit; [DW-1 -: IW] = dst_idx, [DW-IW-1:0] = payload
- o_valid  out  1  payload valid to local consumer
- o_ready  in  1  local consumer accept
- o_data  out  DW-IW  payload (header stripped)
- clr_stats  in  1  clears pkt_cnt, drop_cnt, err_misroute, err_dst
- pkt_cnt  out  16  delivered (popped) payload count, saturating
- drop_cnt  out  8  misrouted flit count, saturating
- err_misroute  out  1  sticky: at least one misrouted flit received
- err_dst  out  IW  dst_idx of the first misrouted flit since clear

Behaviour:
Clock, reset and transfer rules
- Single clock domain.
- rst sampled on the rising edge; all state is cleared in the same cycle.
- Reset values: i_ready=0 during reset, then 1 on the first cycle after reset (FIFO empty); o_valid=0, o_data=0, pkt_cnt=0, drop_cnt=0, err_misroute=0, err_dst=0.
- Reset asserted mid-operation discards FIFO contents with no partial outputs.
- Accept = i_valid & i_ready. Pop = o_valid & o_ready.

Input side
- i_ready = !full. It depends only on registered occupancy and never combinationally on o_ready or i_valid.
- When full, no accept occurs, even if a pop happens in the same cycle.
- Accept with dst_idx == PORT_ID: payload is pushed.
- Accept with dst_idx != PORT_ID: flit is consumed but not pushed.
  - drop_cnt increments, saturating at 255.
  - err_misroute is set.
  - err_dst captures dst_idx only if err_misroute was 0 (first error wins).

Output side
- o_valid = !empty.
- o_data = head entry, read from the registered storage array; o_data is 0 when empty.
- Latency: a flit accepted at edge k is visible on o_valid/o_data after edge k; one cycle input to output.
- o_data and o_valid hold stable while o_valid & !o_ready.

FIFO pointers
- Read and write pointers are IW_F+1 bits, where IW_F = $clog2(DEPTH); the extra MSB distinguishes wrap.
- full = pointers differ only in the MSB.
- empty = pointers are equal.
- Pointers wrap modulo 2*DEPTH.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged and both pointers advance.
- Push into empty with no pop: o_valid rises the next cycle.

Statistics
- pkt_cnt increments on each pop, saturating at 0xFFFF.
- clr_stats has priority over same-cycle increments: counters read 0 after a clear cycle, and err_misroute/err_dst clear.
- clr_stats does not affect FIFO contents.

Decomposition:
- Package bfly_pkg:
  - localparam function idx_w(N) = $clog2(N).
  - Header field offset/width helpers: hdr_lsb(DW,N) = DW - idx_w(N).
  - typedef of the stats struct {pkt_cnt, drop_cnt, err_misroute, err_dst}.
- Sub-module bfly_sync_fifo (WIDTH, DEPTH):
  - push/pop/full/empty/head interface with the pointer scheme above.
  - Reused by future ingress stages.
- Top level holds the route check, drop logic and statistics.

Test Plan:
All scenarios use DW=35, N=8, PORT_ID=3, DEPTH=4.
- Reset release: hold rst 3 cycles, then drop it. Required: i_ready=1 on the next cycle; o_valid=0 and all counters 0 throughout.
- Single flit: i_data={3'd3,32'h0000_0005} with o_ready=1. Required: o_valid=1 with o_data=32'h5 exactly one cycle after accept; pkt_cnt=1.
- Fill and backpressure: o_ready=0, present 5 flits with dst=3 and payloads 1..5. Required: the first 4 are accepted and i_ready=0 after the 4th. Then raise o_ready: output order is 1,2,3,4, and flit 5 is accepted one cycle after the first pop frees a slot.
- Misroute: send {3'd5,32'hAA} then {3'd6,32'hBB}. Required: nothing is pushed; drop_cnt=2, err_misroute=1, err_dst=5; i_ready stays 1.
- Streaming with wrap: 20 flits of dst=3, payloads 0..19, with o_ready toggling 1,0. Required: all 20 are delivered in order with no loss or duplication; pkt_cnt=20.
- Clear collision: clr_stats asserted in the same cycle as a pop and a misroute. Required: next cycle pkt_cnt=0, drop_cnt=0, err_misroute=0; FIFO occupancy reflects the pop.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared definitions for butterfly network stages: header field geometry and
// the statistics record kept by each egress port.
package bfly_pkg;

   // Widest port index the stats record can hold (networks up to 256 ports).
   localparam int STAT_DST_W = 8;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

   function automatic int hdr_lsb(input int dw, input int n);
      return dw - idx_w(n);
   endfunction

   typedef struct packed {
      logic [15:0]           pkt_cnt;
      logic [7:0]            drop_cnt;
      logic                  err_misroute;
      logic [STAT_DST_W-1:0] err_dst;
   } stats_t;

endpackage

// File: rtl/bfly_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is read from registered storage
// and forced to zero while empty.
module bfly_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Same slot index but opposite wrap bit means the writer is a full lap ahead.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/butterfly_egress_port.sv
// Egress stage for one butterfly output: checks the routed destination, strips the
// header, buffers payloads for the local consumer and keeps delivery/misroute stats.
module butterfly_egress_port
   import bfly_pkg::*;
#(
   parameter int DW      = 35,
   parameter int N       = 8,
   parameter int PORT_ID = 0,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_valid,
   output logic                       i_ready,
   input  logic [DW-1:0]              i_data,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic [hdr_lsb(DW,N)-1:0]   o_data,
   input  logic                       clr_stats,
   output logic [15:0]                pkt_cnt,
   output logic [7:0]                 drop_cnt,
   output logic                       err_misroute,
   output logic [idx_w(N)-1:0]        err_dst
);

   localparam int IW = idx_w(N);
   localparam int PW = hdr_lsb(DW, N);
   localparam logic [IW-1:0] MY_IDX = IW'(PORT_ID);

   logic [IW-1:0] w_dst;
   logic [PW-1:0] w_payload;
   logic          w_accept;
   logic          w_push;
   logic          w_misroute;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   stats_t        r_stats;

   assign w_dst     = i_data[DW-1 -: IW];
   assign w_payload = i_data[PW-1:0];

   // Misrouted flits are still accepted so they cannot block the network port.
   assign i_ready    = ~w_full & ~rst;
   assign w_accept   = i_valid & i_ready;
   assign w_push     = w_accept & (w_dst == MY_IDX);
   assign w_misroute = w_accept & (w_dst != MY_IDX);
   assign o_valid    = ~w_empty;
   assign w_pop      = o_valid & o_ready;

   bfly_sync_fifo #(
      .WIDTH (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_payload),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (o_data)
   );

   // A clear wins over any increment or capture landing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         r_stats <= '0;
      end else begin
         if (w_pop && (r_stats.pkt_cnt != 16'hFFFF))
            r_stats.pkt_cnt <= r_stats.pkt_cnt + 16'd1;
         if (w_misroute) begin
            if (r_stats.drop_cnt != 8'hFF)
               r_stats.drop_cnt <= r_stats.drop_cnt + 8'd1;
            r_stats.err_misroute <= 1'b1;
            if (!r_stats.err_misroute)
               r_stats.err_dst <= STAT_DST_W'(w_dst);
         end
      end
   end

   assign pkt_cnt      = r_stats.pkt_cnt;
   assign drop_cnt     = r_stats.drop_cnt;
   assign err_misroute = r_stats.err_misroute;
   assign err_dst      = IW'(r_stats.err_dst);

endmodule

// File: tb/tb_butterfly_egress_port.sv
// Bench for butterfly_egress_port (N=8, PORT_ID=3, DEPTH=4): directed vector table,
// hand-written corner sequences and random traffic against a queue-based model.
module tb_butterfly_egress_port;

   localparam int DW      = 35;
   localparam int N       = 8;
   localparam int PORT_ID = 3;
   localparam int DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        i_ready;
   logic [34:0] i_data;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_data;
   logic        clr_stats;
   logic [15:0] pkt_cnt;
   logic [7:0]  drop_cnt;
   logic        err_misroute;
   logic [2:0]  err_dst;

   int testsRun    = 0;
   int testsFailed = 0;

   // Behavioural model: payload queue plus plain counters.
   int unsigned mq[$];
   int unsigned mPkt    = 0;
   int unsigned mDrop   = 0;
   bit          mErr    = 1'b0;
   int unsigned mErrDst = 0;
   bit          mAcc;
   bit          mPop;
   int          mPopCnt = 0;
   logic [31:0] dutPops[$];

   typedef struct {
      logic        v;
      logic [2:0]  dst;
      logic [31:0] pay;
      logic        ordy;
      logic        clr;
      logic        eRdy;
      logic        eVal;
      logic [31:0] eData;
      logic [15:0] ePkt;
      logic [7:0]  eDrop;
      logic        eErr;
      logic [2:0]  eDst;
   } vec_t;

   vec_t vecs[5];

   butterfly_egress_port #(
      .DW      (DW),
      .N       (N),
      .PORT_ID (PORT_ID),
      .DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .i_ready      (i_ready),
      .i_data       (i_data),
      .o_valid      (o_valid),
      .o_ready      (o_ready),
      .o_data       (o_data),
      .clr_stats    (clr_stats),
      .pkt_cnt      (pkt_cnt),
      .drop_cnt     (drop_cnt),
      .err_misroute (err_misroute),
      .err_dst      (err_dst)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic v, input logic [2:0] dst, input logic [31:0] pay,
                                input logic ordy, input logic clr);
      i_valid   = v;
      i_data    = {dst, pay};
      o_ready   = ordy;
      clr_stats = clr;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit expReady();
      return (rst !== 1'b1) && (mq.size() < DEPTH);
   endfunction

   task automatic checkAll();
      logic [31:0] expData;
      expData = (mq.size() > 0) ? mq[0] : 32'd0;
      checkOutput("i_ready", 32'(i_ready), 32'(expReady()));
      checkOutput("o_valid", 32'(o_valid), 32'(mq.size() > 0));
      checkOutput("o_data", o_data, expData);
      checkOutput("pkt_cnt", 32'(pkt_cnt), mPkt);
      checkOutput("drop_cnt", 32'(drop_cnt), mDrop);
      checkOutput("err_misroute", 32'(err_misroute), 32'(mErr));
      checkOutput("err_dst", 32'(err_dst), mErrDst);
   endtask

   // Advances the model across one rising edge using the inputs currently driven.
   task automatic modelEdge();
      bit          rdy;
      bit          vld;
      int unsigned dst;
      logic [31:0] pay;
      rdy  = expReady();
      vld  = (mq.size() > 0);
      dst  = int'(i_data >> 32);
      pay  = i_data[31:0];
      mAcc = 1'b0;
      mPop = 1'b0;
      if (rst === 1'b1) begin
         mq.delete();
         mPkt = 0; mDrop = 0; mErr = 1'b0; mErrDst = 0;
      end else begin
         mPop = vld && (o_ready === 1'b1);
         mAcc = rdy && (i_valid === 1'b1);
         if (mPop) begin
            void'(mq.pop_front());
            mPopCnt++;
         end
         if (mAcc && dst == PORT_ID) mq.push_back(pay);
         if (clr_stats === 1'b1) begin
            mPkt = 0; mDrop = 0; mErr = 1'b0; mErrDst = 0;
         end else begin
            if (mPop && mPkt < 65535) mPkt++;
            if (mAcc && dst != PORT_ID) begin
               if (mDrop < 255) mDrop++;
               if (!mErr) mErrDst = dst;
               mErr = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      checkAll();
      if (o_valid === 1'b1 && o_ready === 1'b1) dutPops.push_back(o_data);
      modelEdge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] cur;
      logic [31:0] sent;
      int unsigned pick;

      vecs[0] = '{1'b1, 3'd3, 32'h5,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 16'd0, 8'd0, 1'b0, 3'd0};
      vecs[1] = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h5, 16'd0, 8'd0, 1'b0, 3'd0};
      vecs[2] = '{1'b1, 3'd5, 32'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 16'd1, 8'd0, 1'b0, 3'd0};
      vecs[3] = '{1'b1, 3'd6, 32'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 16'd1, 8'd1, 1'b1, 3'd5};
      vecs[4] = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 16'd1, 8'd2, 1'b1, 3'd5};

      // Reset held over three rising edges.
      rst = 1'b1;
      applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      step();
      step();
      rst = 1'b0;

      // Single flit followed by two misroutes, checked against hand-written values.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].v, vecs[i].dst, vecs[i].pay, vecs[i].ordy, vecs[i].clr);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_i_ready", i), 32'(i_ready), 32'(vecs[i].eRdy));
         checkOutput($sformatf("vec%0d_o_valid", i), 32'(o_valid), 32'(vecs[i].eVal));
         checkOutput($sformatf("vec%0d_o_data", i), o_data, vecs[i].eData);
         checkOutput($sformatf("vec%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(vecs[i].ePkt));
         checkOutput($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].eDrop));
         checkOutput($sformatf("vec%0d_err_misroute", i), 32'(err_misroute), 32'(vecs[i].eErr));
         checkOutput($sformatf("vec%0d_err_dst", i), 32'(err_dst), 32'(vecs[i].eDst));
         modelEdge();
         @(posedge clk);
         #1;
      end

      // Fill with the consumer stalled, then drain; flit 5 waits for the first pop.
      cur = 32'd1;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 3'd3, cur, 1'b0, 1'b0);
         step();
         if (mAcc) cur++;
      end
      checkOutput("fill_i_ready_low", 32'(i_ready), 32'd0);
      checkOutput("fill_head", o_data, 32'd1);
      dutPops.delete();
      mPopCnt = 0;
      for (int c = 0; c < 30 && mPopCnt < 5; c++) begin
         applyStimulus(cur <= 32'd5, 3'd3, cur, 1'b1, 1'b0);
         step();
         if (mAcc) cur++;
      end
      checkOutput("fill_pop_count", dutPops.size(), 32'd5);
      for (int i = 0; i < 5; i++)
         checkOutput($sformatf("fill_order%0d", i),
                     (i < dutPops.size()) ? dutPops[i] : 32'hDEAD_BEEF, 32'(i + 1));

      // Streaming through several pointer wraps with a toggling consumer.
      applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
      step();
      sent = 32'd0;
      dutPops.delete();
      mPopCnt = 0;
      for (int c = 0; c < 200 && mPopCnt < 20; c++) begin
         applyStimulus(sent < 32'd20, 3'd3, sent, (c % 2) == 0, 1'b0);
         step();
         if (mAcc) sent++;
      end
      checkOutput("stream_pop_count", dutPops.size(), 32'd20);
      for (int i = 0; i < 20; i++)
         checkOutput($sformatf("stream_order%0d", i),
                     (i < dutPops.size()) ? dutPops[i] : 32'hDEAD_BEEF, 32'(i));
      checkOutput("stream_pkt_cnt", 32'(pkt_cnt), 32'd20);

      // Clear in the same cycle as a pop and a misroute.
      applyStimulus(1'b1, 3'd3, 32'hA1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 3'd3, 32'hA2, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 3'd7, 32'hCC, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 3'd5, 32'hDD, 1'b1, 1'b1);
      step();
      applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("clr_pkt_cnt", 32'(pkt_cnt), 32'd0);
      checkOutput("clr_drop_cnt", 32'(drop_cnt), 32'd0);
      checkOutput("clr_err_misroute", 32'(err_misroute), 32'd0);
      checkOutput("clr_err_dst", 32'(err_dst), 32'd0);
      checkOutput("clr_o_valid", 32'(o_valid), 32'd1);
      checkOutput("clr_head", o_data, 32'hA2);
      step();

      // Drop counter saturation; first misroute destination must stick.
      applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
      step();
      for (int k = 0; k < 260; k++) begin
         pick = $urandom_range(0, 7);
         if (pick == PORT_ID) pick = 4;
         if (k == 0) pick = 6;
         applyStimulus(1'b1, 3'(pick), $urandom, 1'($urandom % 2), 1'b0);
         step();
      end
      checkOutput("sat_drop_cnt", 32'(drop_cnt), 32'd255);
      checkOutput("sat_err_dst", 32'(err_dst), 32'd6);
      checkOutput("sat_err_misroute", 32'(err_misroute), 32'd1);

      // Random traffic with a reset pulse in the middle.
      for (int c = 0; c < 400; c++) begin
         rst  = (c == 200 || c == 201);
         pick = (($urandom % 5) == 0) ? $urandom_range(0, 7) : PORT_ID;
         applyStimulus(($urandom % 4) != 0, 3'(pick), $urandom, 1'($urandom % 2),
                       ($urandom % 40) == 0);
         step();
      end
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
